// File: rtl/student_ctrl.sv
// student_ctrl: moves the student sprite horizontally and runs its jump arc.
// Buttons are synchronized, and all motion advances once per unpaused frame tick.
// Optional build macro STUDENT_WRAP_EN makes horizontal motion wrap to the
// opposite screen edge. Without it, horizontal motion clamps at the edges.
// Handshake: upd_done is a one-cycle pulse in the cycle after each
// tick-driven update. It has no ready and cannot be back-pressured.
module student_ctrl #(
   parameter int SCREEN_W   = 640,
   parameter int SPRITE_SZ  = 32,
   parameter int GROUND_Y   = 416,
   parameter int STEP_X     = 2,
   parameter int STEP_Y     = 4,
   parameter int JUMP_H     = 64,
   parameter int APEX_TICKS = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_tick,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_jump,
   input  logic        pause,
   output logic [10:0] student_x,
   output logic [9:0]  student_y,
   output logic [1:0]  jump_state,
   output logic        facing_left,
   output logic        upd_done
);

   localparam int X_MAX  = SCREEN_W - SPRITE_SZ;
   localparam int APEX_Y = GROUND_Y - JUMP_H;
   localparam int CW     = (APEX_TICKS > 1) ? $clog2(APEX_TICKS) : 1;

   localparam logic [11:0]   STEP_X_W  = 12'(STEP_X);
   localparam logic [11:0]   X_MAX_W   = 12'(X_MAX);
   localparam logic [10:0]   X_MAX_N   = 11'(X_MAX);
   localparam logic [10:0]   X_HOME    = 11'(X_MAX / 2);
   localparam logic [10:0]   STEP_Y_W  = 11'(STEP_Y);
   localparam logic [10:0]   GROUND_W  = 11'(GROUND_Y);
   localparam logic [10:0]   APEX_W    = 11'(APEX_Y);
   localparam logic [9:0]    GROUND_N  = 10'(GROUND_Y);
   localparam logic [9:0]    APEX_N    = 10'(APEX_Y);
   localparam logic [CW-1:0] APEX_LAST = CW'(APEX_TICKS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RISE = 2'd1,
      S_APEX = 2'd2,
      S_FALL = 2'd3
   } jump_t;

   jump_t         state_q, state_next;
   logic [10:0]   x_q, x_next;
   logic [9:0]    y_q, y_next;
   logic          facing_q, facing_next;
   logic [CW-1:0] cnt_q, cnt_next;
   logic          upd_pend;
   logic [1:0]    left_sync, right_sync, jump_sync;
   logic          left_s, right_s, jump_s;
   logic          valid;
   logic [11:0]   x_sum, x_dif;
   logic [10:0]   y_inc, y_dec;

   assign left_s  = left_sync[1];
   assign right_s = right_sync[1];
   assign jump_s  = jump_sync[1];
   assign valid   = frame_tick & ~pause;

   assign student_x   = x_q;
   assign student_y   = y_q;
   assign jump_state  = state_q;
   assign facing_left = facing_q;

   // Two-flop synchronizers bring the asynchronous buttons into the clk domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         left_sync  <= 2'b00;
         right_sync <= 2'b00;
         jump_sync  <= 2'b00;
      end else begin
         left_sync  <= {left_sync[0], btn_left};
         right_sync <= {right_sync[0], btn_right};
         jump_sync  <= {jump_sync[0], btn_jump};
      end
   end

   // Horizontal step with edge handling: clamp by default, wrap when enabled.
   always_comb begin
      x_next      = x_q;
      facing_next = facing_q;
      x_sum       = {1'b0, x_q} + STEP_X_W;
      x_dif       = {1'b0, x_q} - STEP_X_W;
      if (valid) begin
         if (left_s && !right_s) begin
            facing_next = 1'b1;
            if ({1'b0, x_q} < STEP_X_W) begin
`ifdef STUDENT_WRAP_EN
               x_next = X_MAX_N;
`else
               x_next = 11'd0;
`endif
            end else begin
               x_next = x_dif[10:0];
            end
         end else if (right_s && !left_s) begin
            facing_next = 1'b0;
            if (x_sum > X_MAX_W) begin
`ifdef STUDENT_WRAP_EN
               x_next = 11'd0;
`else
               x_next = X_MAX_N;
`endif
            end else begin
               x_next = x_sum[10:0];
            end
         end
      end
   end

   // Jump FSM next state: rise to the apex, hold for APEX_TICKS ticks, fall to ground.
   always_comb begin
      state_next = state_q;
      y_next     = y_q;
      cnt_next   = cnt_q;
      y_inc      = {1'b0, y_q} + STEP_Y_W;
      y_dec      = {1'b0, y_q} - STEP_Y_W;
      if (valid) begin
         case (state_q)
            S_IDLE: begin
               if (jump_s) begin
                  // The tick that launches the jump also takes the first step up.
                  if (y_dec <= APEX_W) begin
                     y_next     = APEX_N;
                     state_next = S_APEX;
                  end else begin
                     y_next     = y_dec[9:0];
                     state_next = S_RISE;
                  end
                  cnt_next = '0;
               end
            end
            S_RISE: begin
               if (y_dec <= APEX_W) begin
                  y_next     = APEX_N;
                  state_next = S_APEX;
                  cnt_next   = '0;
               end else begin
                  y_next = y_dec[9:0];
               end
            end
            S_APEX: begin
               if (cnt_q == APEX_LAST) begin
                  state_next = S_FALL;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt_q + 1'b1;
               end
            end
            S_FALL: begin
               if (y_inc >= GROUND_W) begin
                  y_next     = GROUND_N;
                  state_next = S_IDLE;
               end else begin
                  y_next = y_inc[9:0];
               end
            end
            default: begin
               state_next = S_IDLE;
               y_next     = GROUND_N;
               cnt_next   = '0;
            end
         endcase
      end
   end

   // State and position registers. Reset puts the sprite at centre, on the ground.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_IDLE;
         x_q      <= X_HOME;
         y_q      <= GROUND_N;
         facing_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_next;
         x_q      <= x_next;
         y_q      <= y_next;
         facing_q <= facing_next;
         cnt_q    <= cnt_next;
      end
   end

   // upd_done trails the output update by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         upd_pend <= 1'b0;
         upd_done <= 1'b0;
      end else begin
         upd_pend <= valid;
         upd_done <= upd_pend;
      end
   end

endmodule

// File: tb/tb_student_ctrl.sv
// tb_student_ctrl: directed tests for student_ctrl with a scoreboard queue.
// Expected positions are pushed as ticks are issued. A monitor checks them on upd_done.
module tb_student_ctrl;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        frame_tick = 1'b0;
   logic        btn_left = 1'b0;
   logic        btn_right = 1'b0;
   logic        btn_jump = 1'b0;
   logic        pause = 1'b0;
   logic [10:0] student_x;
   logic [9:0]  student_y;
   logic [1:0]  jump_state;
   logic        facing_left;
   logic        upd_done;

   int checks = 0;
   int passed = 0;
   int upd_cnt = 0;
   int ex, ey, es, ef;
   logic [23:0] exp_q[$];
   logic [23:0] mon_e;

   always #5 clk = ~clk;

   student_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frame_tick  (frame_tick),
      .btn_left    (btn_left),
      .btn_right   (btn_right),
      .btn_jump    (btn_jump),
      .pause       (pause),
      .student_x   (student_x),
      .student_y   (student_y),
      .jump_state  (jump_state),
      .facing_left (facing_left),
      .upd_done    (upd_done)
   );

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Monitor: pop one expected position for every upd_done pulse.
   always @(negedge clk) begin
      if (rst_n && upd_done) begin
         upd_cnt++;
         if (exp_q.size() == 0) begin
            check("unexpected_upd_done", 1, 0);
         end else begin
            mon_e = exp_q.pop_front();
            check("student_x", int'(student_x), int'(mon_e[23:13]));
            check("student_y", int'(student_y), int'(mon_e[12:3]));
            check("jump_state", int'(jump_state), int'(mon_e[2:1]));
            check("facing_left", int'(facing_left), int'(mon_e[0]));
         end
      end
   end

   task automatic set_btn(input logic l, input logic r, input logic j);
      @(posedge clk);
      #1;
      btn_left  = l;
      btn_right = r;
      btn_jump  = j;
      repeat (3) @(posedge clk);
   endtask

   // One frame tick. If the tick should be processed, the expected state is queued first.
   task automatic tick(input bit expect_upd);
      if (expect_upd) exp_q.push_back({11'(ex), 10'(ey), 2'(es), 1'(ef)});
      @(posedge clk);
      #1;
      frame_tick = 1'b1;
      @(posedge clk);
      #1;
      frame_tick = 1'b0;
      repeat (3) @(posedge clk);
   endtask

   task automatic home();
      ex = 304; ey = 416; es = 0; ef = 0;
   endtask

   // Full jump from the ground, with dx added to x on every tick.
   task automatic full_jump(input int dx, input bit first_done);
      for (int i = (first_done ? 2 : 1); i <= 16; i++) begin
         ex += dx; ey = 416 - 4 * i; es = (i == 16) ? 2 : 1; tick(1);
      end
      for (int i = 1; i <= 8; i++) begin
         ex += dx; ey = 352; es = (i == 8) ? 3 : 2; tick(1);
      end
      for (int i = 1; i <= 16; i++) begin
         ex += dx; ey = 352 + 4 * i; es = (i == 16) ? 0 : 3; tick(1);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      int u;
      // Reset
      #2 rst_n = 1'b0;
      #1;
      check("rst_x", int'(student_x), 304);
      check("rst_y", int'(student_y), 416);
      check("rst_state", int'(jump_state), 0);
      check("rst_facing", int'(facing_left), 0);
      check("rst_upd", int'(upd_done), 0);
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      home();

      // Five ticks with right held
      set_btn(0, 1, 0);
      for (int i = 0; i < 5; i++) begin ex += 2; tick(1); end
      check("right5_x", int'(student_x), 314);
      check("right5_upd_count", upd_cnt, 5);

      // Left three ticks
      set_btn(1, 0, 0);
      for (int i = 0; i < 3; i++) begin ex -= 2; ef = 1; tick(1); end

      // Both held: no motion, facing held
      set_btn(1, 1, 0);
      for (int i = 0; i < 4; i++) tick(1);
      check("both_x", int'(student_x), 308);
      check("both_facing", int'(facing_left), 1);

      // Pause freezes motion and suppresses upd_done
      u = upd_cnt;
      @(posedge clk); #1 pause = 1'b1;
      set_btn(0, 1, 0);
      for (int i = 0; i < 3; i++) tick(0);
      check("pause_upd_count", upd_cnt, u);
      check("pause_x", int'(student_x), 308);
      check("pause_facing", int'(facing_left), 1);
      @(posedge clk); #1 pause = 1'b0;

      // Jump held throughout: full arc, then an immediate relaunch
      set_btn(0, 0, 1);
      full_jump(0, 0);
      ey = 412; es = 1; tick(1);
      set_btn(0, 0, 0);
      for (int i = 2; i <= 16; i++) begin
         ey = 416 - 4 * i; es = (i == 16) ? 2 : 1; tick(1);
      end
      for (int i = 0; i < 3; i++) tick(1);
      check("apex_queue_drained", exp_q.size(), 0);

      // Asynchronous reset during the apex
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("apex_rst_x", int'(student_x), 304);
      check("apex_rst_y", int'(student_y), 416);
      check("apex_rst_state", int'(jump_state), 0);
      check("apex_rst_facing", int'(facing_left), 0);
      @(negedge clk) rst_n = 1'b1;
      home();

      // Jump while moving right, with a full apex after reset
      set_btn(0, 1, 1);
      ex = 306; ey = 412; es = 1; tick(1);
      set_btn(0, 1, 0);
      full_jump(2, 1);
      check("jump_move_x", int'(student_x), 384);

      // Right edge
      while (ex < 608) begin ex += 2; tick(1); end
`ifdef STUDENT_WRAP_EN
      ex = 0;
`else
      ex = 608;
`endif
      tick(1);

      // Left edge, starting again from the centre
      @(negedge clk) rst_n = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      home();
      set_btn(1, 0, 0);
      ef = 1;
      while (ex > 0) begin ex -= 2; tick(1); end
`ifdef STUDENT_WRAP_EN
      ex = 608;
`else
      ex = 0;
`endif
      tick(1);

      repeat (10) @(posedge clk);
      check("final_queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/student_ctrl.md
STUDENT_CTRL -- requirements
Module: student_ctrl

Interface
REQ-001 Parameter SCREEN_W, 640, visible width in pixels.
REQ-002 Parameter SPRITE_SZ, 32, sprite edge in pixels; max x = SCREEN_W-SPRITE_SZ (608).
REQ-003 Parameter GROUND_Y, 416, student_y when standing.
REQ-004 Parameter STEP_X, 2, horizontal pixels per frame tick.
REQ-005 Parameter STEP_Y, 4, vertical pixels per tick while rising or falling.
REQ-006 Parameter JUMP_H, 64, apex height above GROUND_Y; multiple of STEP_Y.
REQ-007 Parameter APEX_TICKS, 8, ticks held at apex.
REQ-008 Port clk, input, 1, single system clock; all state on rising edge.
REQ-009 Port rst_n, input, 1, asynchronous active-low reset.
REQ-010 Port frame_tick, input, 1, one-cycle pulse per frame, synchronous to clk.
REQ-011 Port btn_left, btn_right, btn_jump, input, 1 each, asynchronous push buttons, active-high.
REQ-012 Port pause, input, 1, synchronous; freezes all motion while high.
REQ-013 Port student_x, output, 11, sprite left edge, registered.
REQ-014 Port student_y, output, 10, sprite top edge, registered.
REQ-015 Port jump_state, output, 2, 0=IDLE 1=RISE 2=APEX 3=FALL, registered.
REQ-016 Port facing_left, output, 1, last horizontal direction, registered.
REQ-017 Port upd_done, output, 1, one-cycle pulse in the cycle after any tick-driven update.

Function
REQ-018 Each button SHALL pass through a 2-flop synchronizer; only synchronized values SHALL be used.
REQ-019 State SHALL change only in the cycle after a frame_tick with pause low; otherwise all outputs except upd_done SHALL hold.
REQ-020 Horizontal: left-only subtracts STEP_X, right-only adds STEP_X; both or neither leaves student_x unchanged.
REQ-021 facing_left SHALL be set by left-only, cleared by right-only, held otherwise.
REQ-022 Without STUDENT_WRAP_EN, student_x SHALL clamp to [0, 608]; no intermediate underflow (x<STEP_X moving left yields 0).
REQ-023 IDLE: synchronized btn_jump high at a valid tick -> RISE; student_y stays GROUND_Y until then.
REQ-024 RISE: student_y decreases by STEP_Y per valid tick; on reaching GROUND_Y-JUMP_H (352) -> APEX in that same update.
REQ-025 APEX: student_y held; tick counter counts valid ticks; after APEX_TICKS ticks -> FALL.
REQ-026 FALL: student_y increases by STEP_Y per valid tick; on reaching GROUND_Y -> IDLE; student_y never exceeds GROUND_Y.
REQ-027 btn_jump in RISE, APEX or FALL SHALL be ignored; holding it through landing starts a new jump on the next valid tick from IDLE.
REQ-028 Horizontal motion SHALL apply in every jump state.
REQ-029 upd_done SHALL pulse exactly once per valid tick, one cycle after outputs update; never while pause high.
REQ-030 Arithmetic SHALL use at least 12-bit intermediates for x and 11-bit for y before clamping.

Reset
REQ-031 On rst_n low, immediately: student_x=304 ((SCREEN_W-SPRITE_SZ)/2), student_y=GROUND_Y, jump_state=IDLE, facing_left=0, upd_done=0, apex counter=0, synchronizers=0.
REQ-032 Reset mid-jump SHALL return to ground/IDLE with no residual counter state.
REQ-033 First valid tick after rst_n deasserts SHALL be processed normally.

Configuration
REQ-034 Macro STUDENT_WRAP_EN defined: moving right past 608 yields 0, moving left below 0 yields 608 (wrap to opposite edge, no partial step).
REQ-035 STUDENT_WRAP_EN undefined: clamp per REQ-022; all other behaviour identical.

Verification
REQ-036 Reset, then 5 ticks with btn_right held -> student_x=314, facing_left=0, 5 upd_done pulses.
REQ-037 Jump pressed from IDLE at x=304 -> y 412,408..352 over 16 ticks, 8 ticks at 352, 16 ticks back to 416, jump_state sequence 1,2,3,0.
REQ-038 x=1, btn_left held, 1 tick -> x=0 (wrap off) or x=608 (STUDENT_WRAP_EN defined).
REQ-039 btn_left and btn_right both held 4 ticks -> x and facing_left unchanged; pause high with ticks -> no change, no upd_done.
REQ-040 rst_n asserted during APEX -> asynchronously y=416, jump_state=0, x=304; next jump has full 8-tick apex.
